led_trail_pwm: RTL and testbench

- Downstream stage of the LED scanner.
- Consumes the scanner's 10-bit position pattern and drives the physical LEDs with PWM, so each lit LED fades out over several frames after the scan moves on (the "trail" effect).
- Holds one brightness register per LED, updated only at PWM frame boundaries so outputs never glitch mid-period.

---
 rtl/led_trail_pwm.sv | 84 ++++++++
 tb/tb_led_trail_pwm.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/led_trail_pwm.sv
// LED trail PWM driver: per-LED brightness (MAX on hit, decays per frame); optional LED_TRAIL_GAMMA_EN squares duty.
// Latency: 1 cycle counter/brightness to led_out; brightness changes only on frame boundaries.
// Backpressure: none; pattern strobes always accepted (last wins), enable=0 freezes timing and blanks output.
module led_trail_pwm #(
  parameter int NUM_LEDS   = 10,
  parameter int PWM_BITS   = 4,
  parameter int PRESCALE   = 8,
  parameter int DECAY_STEP = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_LEDS-1:0] pattern_in,
  input  logic                pattern_valid,
  input  logic                enable,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                frame_start
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] MAXV    = '1;
  localparam logic [PWM_BITS:0]   DEC     = (PWM_BITS + 1)'(DECAY_STEP);

  logic [PS_W-1:0]                         prescale_cnt;
  logic [PWM_BITS-1:0]                     pwm_cnt;
  logic [NUM_LEDS-1:0]                     pattern_q;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0]       bright;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0]       next_bright;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0]       duty;
  logic [NUM_LEDS-1:0]                     led_nxt;
  logic                                    tick;
  logic                                    boundary;

  assign tick     = enable && (prescale_cnt == PS_LAST);
  assign boundary = tick && (pwm_cnt == MAXV);

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
    logic              eff_bit;
    logic [PWM_BITS:0] diff;

    // A strobe landing on the boundary cycle takes effect in the frame that starts next.
    assign eff_bit = pattern_valid ? pattern_in[i] : pattern_q[i];
    assign diff    = {1'b0, bright[i]} - DEC;
    assign next_bright[i] = eff_bit ? MAXV
                          : (diff[PWM_BITS] ? '0 : diff[PWM_BITS-1:0]);

`ifdef LED_TRAIL_GAMMA_EN
    logic [2*PWM_BITS-1:0] prod;
    assign prod    = {{PWM_BITS{1'b0}}, bright[i]} * {{PWM_BITS{1'b0}}, bright[i]};
    assign duty[i] = prod[2*PWM_BITS-1:PWM_BITS];
`else
    assign duty[i] = bright[i];
`endif

    assign led_nxt[i] = enable && (pwm_cnt < duty[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_cnt <= '0;
      pwm_cnt      <= '0;
      pattern_q    <= '0;
      bright       <= '0;
      led_out      <= '0;
      frame_start  <= 1'b0;
    end else begin
      if (enable) begin
        prescale_cnt <= tick ? '0 : prescale_cnt + 1'b1;
      end
      if (tick) begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
      if (pattern_valid) begin
        pattern_q <= pattern_in;
      end
      if (boundary) begin
        bright <= next_bright;
      end
      led_out     <= led_nxt;
      frame_start <= boundary;
    end
  end

endmodule

// File: tb/tb_led_trail_pwm.sv
// Randomized bench for led_trail_pwm against a frame-arithmetic reference model.
module tb_led_trail_pwm;
  localparam int N     = 10;
  localparam int PB    = 4;
  localparam int PS    = 2;
  localparam int DS    = 2;
  localparam int MAXV  = 15;
  localparam int FRAME = PS * (MAXV + 1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] pattern_in = '0;
  logic         pattern_valid = 1'b0;
  logic         enable = 1'b0;
  logic [N-1:0] led_out;
  logic         frame_start;

  int checks = 0;
  int errors = 0;

  // Reference model: enabled-cycle count since reset, brightness per LED, held pattern.
  int           en_cycles = 0;
  int           bri [N];
  logic [N-1:0] pat_m = '0;

  led_trail_pwm #(.NUM_LEDS(N), .PWM_BITS(PB), .PRESCALE(PS), .DECAY_STEP(DS)) dut (
    .clk(clk), .rst_n(rst_n), .pattern_in(pattern_in), .pattern_valid(pattern_valid),
    .enable(enable), .led_out(led_out), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int duty_of(input int b);
`ifdef LED_TRAIL_GAMMA_EN
    return (b * b) / (MAXV + 1);
`else
    return b;
`endif
  endfunction

  task automatic model_reset();
    en_cycles = 0;
    pat_m = '0;
    for (int i = 0; i < N; i++) bri[i] = 0;
  endtask

  // One clock with the given inputs; model advances and outputs are checked 1 time unit after the edge.
  task automatic step(input logic en, input logic vld, input logic [N-1:0] p);
    logic [N-1:0] led_e;
    logic         fs_e;
    int           pc;
    enable = en;
    pattern_valid = vld;
    pattern_in = p;
    @(posedge clk);
    pc = (en_cycles / PS) % (MAXV + 1);
    led_e = '0;
    for (int i = 0; i < N; i++) if (en && pc < duty_of(bri[i])) led_e[i] = 1'b1;
    fs_e = en && (en_cycles % FRAME == FRAME - 1);
    if (fs_e) begin
      for (int i = 0; i < N; i++) begin
        if (vld ? p[i] : pat_m[i]) bri[i] = MAXV;
        else bri[i] = (bri[i] > DS) ? bri[i] - DS : 0;
      end
    end
    if (vld) pat_m = p;
    if (en) en_cycles++;
    #1;
    chk("led_out", 32'(led_out), 32'(led_e));
    chk("frame_start", 32'(frame_start), 32'(fs_e));
  endtask

  task automatic idle_until_phase(input int ph);
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (en_cycles % FRAME == ph) break;
      step(1'b1, 1'b0, '0);
    end
  endtask

  // Async reset mid-cycle, then measure distance to the first frame_start.
  task automatic do_reset();
    int first;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_led_out", 32'(led_out), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    model_reset();
    enable = 1'b0;
    pattern_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    first = 0;
    for (int k = 1; k <= FRAME + 8; k++) begin
      step(1'b1, 1'b0, '0);
      if (frame_start === 1'b1 && first == 0) first = k;
    end
    chk("first_frame_start_gap", 32'(first), 32'(FRAME));
  endtask

  initial begin
    int hi;
    logic [N-1:0] rp;
    model_reset();
    #3;
    chk("init_led_out", 32'(led_out), 32'd0);
    chk("init_frame_start", 32'(frame_start), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single LED, then measure one full frame of led0.
    step(1'b1, 1'b1, 10'h001);
    for (int k = 0; k < 3 * FRAME && frame_start !== 1'b1; k++) step(1'b1, 1'b0, '0);
    for (int k = 0; k < FRAME && frame_start !== 1'b1; k++) step(1'b1, 1'b0, '0);
    hi = 0;
    for (int k = 0; k < FRAME; k++) begin
      step(1'b1, 1'b0, '0);
      hi += int'(led_out[0]);
    end
`ifdef LED_TRAIL_GAMMA_EN
    chk("led0_high_cycles", 32'(hi), 32'd28);
`else
    chk("led0_high_cycles", 32'(hi), 32'd30);
`endif

    // Decay of led0 across 10 frames to zero, led1 lit.
    step(1'b1, 1'b1, 10'h002);
    for (int k = 0; k < 10 * FRAME; k++) step(1'b1, 1'b0, '0);
    chk("led0_decayed_to_zero", 32'(bri[0]), 32'd0);

    // Last strobe in a frame wins.
    idle_until_phase(2);
    step(1'b1, 1'b1, 10'h004);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 10'h008);
    for (int k = 0; k < 2 * FRAME; k++) step(1'b1, 1'b0, '0);

    // Strobe exactly on the boundary cycle.
    idle_until_phase(FRAME - 1);
    step(1'b1, 1'b1, 10'h010);
    chk("bypass_frame_start", 32'(frame_start), 32'd1);
    for (int k = 0; k < FRAME; k++) step(1'b1, 1'b0, '0);

    // Freeze mid-frame, then resume.
    idle_until_phase(9);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, '0);
    for (int k = 0; k < 2 * FRAME; k++) step(1'b1, 1'b0, '0);

    do_reset();

    // Randomized traffic with a reset in the middle.
    for (int k = 0; k < 4000; k++) begin
      rp = ($urandom_range(0, 1) == 1) ? (N'(1) << $urandom_range(0, N - 1)) : N'($urandom);
      step($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0, rp);
      if (k == 2000) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
